// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
//   Serialises a captured word LSB-first into an attached "101" sequence
//   detector. It clears the detector before each scan and collects the
//   detector's match flags into a per-bit hit map and a hit count.
//
// Parameters
//   DET_LAT     detector latency in clocks (0..3). This is the delay from a bit
//               on in_seq to its match flag on out_seq.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   data_in     word to scan, sent LSB-first
//   len_in      number of bits to scan; 0 or >16 means 16
//   data_valid  request; captured when data_ready is high
//   data_ready  high only while idle
//   abort       cancels a scan in progress (ignored when idle or done)
//   det_rst     registered synchronous clear to the detector
//   in_seq      registered serial bit to the detector
//   out_seq     detector match flag
//   busy        high whenever not idle
//   done        one-cycle pulse when hit_count/hit_map are final
//   hit_count   number of matches in the last word (saturates at 16)
//   hit_map     bit k set = match attributed to bit index k
module seq_detect_ctrl #(
  parameter int DET_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic [4:0]  len_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic        abort,
  output logic        det_rst,
  output logic        in_seq,
  input  logic        out_seq,
  output logic        busy,
  output logic        done,
  output logic [4:0]  hit_count,
  output logic [15:0] hit_map
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [5:0] LAT6 = 6'(DET_LAT);
  localparam logic [4:0] LAT5 = 5'(DET_LAT);

  function automatic logic [4:0] eff_len(input logic [4:0] l);
    return (l == 5'd0 || l > 5'd16) ? 5'd16 : l;
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] c);
    return (c >= 5'd16) ? 5'd16 : c + 5'd1;
  endfunction

  logic [2:0]  state_q;
  logic [15:0] shreg_q;
  logic [4:0]  len_q;
  logic [4:0]  cyc_q;
  logic        det_rst_q;
  logic        in_seq_q;
  logic [4:0]  hit_count_q;
  logic [15:0] hit_map_q;

  // cyc_q counts SHIFT+DRAIN cycles from the first SHIFT cycle. The sample
  // taken at the end of cycle cyc belongs to bit cyc-DET_LAT. Early cycles
  // give a negative index, which shows up in the sign bit and is discarded.
  logic [5:0]  idx_ext;
  logic        hit_now;
  logic [4:0]  shift_last;
  logic [4:0]  drain_last;

  always_comb begin
    idx_ext    = {1'b0, cyc_q} - LAT6;
    hit_now    = ((state_q == SHIFT) || (state_q == DRAIN)) && out_seq &&
                 !idx_ext[5] && (idx_ext[4:0] < len_q);
    shift_last = len_q - 5'd1;
    drain_last = len_q + LAT5 - 5'd1;
  end

  // Data path: word shift register and length, loaded on handshake only
  always_ff @(posedge clk) begin
    if (state_q == IDLE && data_valid) begin
      shreg_q <= data_in;
      len_q   <= eff_len(len_in);
    end else if (state_q == CLEAR || (state_q == SHIFT && cyc_q != shift_last)) begin
      shreg_q <= shreg_q >> 1;
    end
  end

  // Control: FSM, detector drive and result accumulation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      det_rst_q   <= 1'b1;
      in_seq_q    <= 1'b0;
      cyc_q       <= 5'd0;
      hit_count_q <= 5'd0;
      hit_map_q   <= 16'd0;
    end else begin
      det_rst_q <= 1'b0;
      in_seq_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // Handshake takes priority over abort here; abort is a no-op in IDLE.
          if (data_valid) begin
            state_q     <= CLEAR;
            det_rst_q   <= 1'b1;
            cyc_q       <= 5'd0;
            hit_count_q <= 5'd0;
            hit_map_q   <= 16'd0;
          end
        end
        CLEAR, SHIFT, DRAIN: begin
          if (abort) begin
            state_q     <= IDLE;
            det_rst_q   <= 1'b1;
            cyc_q       <= 5'd0;
            hit_count_q <= 5'd0;
            hit_map_q   <= 16'd0;
          end else if (state_q == CLEAR) begin
            state_q  <= SHIFT;
            in_seq_q <= shreg_q[0];
          end else begin
            if (hit_now) begin
              hit_map_q[idx_ext[3:0]] <= 1'b1;
              hit_count_q             <= sat_inc(hit_count_q);
            end
            cyc_q <= cyc_q + 5'd1;
            if (state_q == SHIFT) begin
              // in_seq is registered, so the next bit is loaded one cycle
              // early and forced low once the last bit has been sent.
              if (cyc_q == shift_last) state_q <= (DET_LAT == 0) ? DONE : DRAIN;
              else                     in_seq_q <= shreg_q[0];
            end else if (cyc_q == drain_last) begin
              state_q <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign det_rst    = det_rst_q;
  assign in_seq     = in_seq_q;
  assign hit_count  = hit_count_q;
  assign hit_map    = hit_map_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl. It uses one DET_LAT=1 instance (a) and one
// DET_LAT=0 instance (b). Each instance drives an overlapping-101 detector
// model. Expected results come from scanning the word's bits for 1,0,1
// windows, and expected timing comes from the cycle-by-cycle timeline
// CLEAR / SHIFT x len / DRAIN x DET_LAT / DONE.
module tb_seq_detect_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] data_in_a, data_in_b;
  logic [4:0]  len_in_a, len_in_b;
  logic        data_valid_a, data_valid_b, abort_a, abort_b;
  logic        data_ready_a, data_ready_b, det_rst_a, det_rst_b;
  logic        in_seq_a, in_seq_b, busy_a, busy_b, done_a, done_b;
  logic        out_seq_a, out_seq_b;
  logic [4:0]  hit_count_a, hit_count_b;
  logic [15:0] hit_map_a, hit_map_b;

  seq_detect_ctrl #(.DET_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset), .data_in(data_in_a), .len_in(len_in_a),
    .data_valid(data_valid_a), .data_ready(data_ready_a), .abort(abort_a),
    .det_rst(det_rst_a), .in_seq(in_seq_a), .out_seq(out_seq_a),
    .busy(busy_a), .done(done_a), .hit_count(hit_count_a), .hit_map(hit_map_a)
  );

  seq_detect_ctrl #(.DET_LAT(0)) u_dut_b (
    .clk(clk), .reset(reset), .data_in(data_in_b), .len_in(len_in_b),
    .data_valid(data_valid_b), .data_ready(data_ready_b), .abort(abort_b),
    .det_rst(det_rst_b), .in_seq(in_seq_b), .out_seq(out_seq_b),
    .busy(busy_b), .done(done_b), .hit_count(hit_count_b), .hit_map(hit_map_b)
  );

  // Overlapping 101 detectors: hist holds {bit t-2, bit t-1}
  logic [1:0] hist_a = 2'b00;
  logic [1:0] hist_b = 2'b00;
  initial out_seq_a = 1'b0;

  always @(posedge clk) begin
    if (det_rst_a) begin
      hist_a    <= 2'b00;
      out_seq_a <= 1'b0;
    end else begin
      hist_a    <= {hist_a[0], in_seq_a};
      out_seq_a <= in_seq_a && (hist_a == 2'b10);
    end
  end

  always @(posedge clk) begin
    if (det_rst_b) hist_b <= 2'b00;
    else           hist_b <= {hist_b[0], in_seq_b};
  end
  assign out_seq_b = in_seq_b && (hist_b == 2'b10);

  // {in_seq, det_rst, done, busy, data_ready}
  logic [4:0] ctl_a, ctl_b;
  assign ctl_a = {in_seq_a, det_rst_a, done_a, busy_a, data_ready_a};
  assign ctl_b = {in_seq_b, det_rst_b, done_b, busy_b, data_ready_b};

  task automatic model(input logic [15:0] w, input int el,
                       output logic [4:0] cnt, output logic [15:0] map);
    cnt = 5'd0;
    map = 16'd0;
    for (int t = 2; t < el; t++)
      if (w[t-2] && !w[t-1] && w[t]) begin
        map[t] = 1'b1;
        cnt    = cnt + 5'd1;
      end
  endtask

  // Full scan on instance sel (0 = a, 1 = b), starting at a negedge and ending
  // at the negedge of the first IDLE cycle after DONE.
  task automatic do_scan(input int sel, input logic [15:0] w, input logic [4:0] l,
                         input logic ab, input string nm);
    int          el, dn;
    logic [4:0]  ecnt, ocnt, ectl, octl;
    logic [15:0] emap, omap;
    logic        ein;
    el = (l == 5'd0 || l > 5'd16) ? 16 : int'(l);
    dn = el + 2 + ((sel == 0) ? 1 : 0);
    model(w, el, ecnt, emap);
    if (sel == 0) begin
      data_in_a = w; len_in_a = l; data_valid_a = 1'b1; abort_a = ab;
    end else begin
      data_in_b = w; len_in_b = l; data_valid_b = 1'b1; abort_b = ab;
    end
    checks++;
    if (((sel == 0) ? data_ready_a : data_ready_b) !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_hs got=0 want=1", nm);
    end
    @(negedge clk);
    if (sel == 0) begin data_valid_a = 1'b0; abort_a = 1'b0; end
    else          begin data_valid_b = 1'b0; abort_b = 1'b0; end
    for (int n = 1; n <= dn + 1; n++) begin
      ein  = (n >= 2 && n <= el + 1) ? w[n-2] : 1'b0;
      ectl = {ein, (n == 1), (n == dn), (n <= dn), (n > dn)};
      octl = (sel == 0) ? ctl_a : ctl_b;
      checks++;
      if (octl !== ectl) begin
        errors++;
        $display("FAIL %s ctl cycle=%0d got=%b want=%b", nm, n, octl, ectl);
      end
      if (n >= dn) begin
        ocnt = (sel == 0) ? hit_count_a : hit_count_b;
        omap = (sel == 0) ? hit_map_a : hit_map_b;
        checks++;
        if ({ocnt, omap} !== {ecnt, emap}) begin
          errors++;
          $display("FAIL %s result cycle=%0d got cnt=%0d map=%h want cnt=%0d map=%h",
                   nm, n, ocnt, omap, ecnt, emap);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data_in_a = 16'd0; len_in_a = 5'd0; data_valid_a = 1'b0; abort_a = 1'b0;
    data_in_b = 16'd0; len_in_b = 5'd0; data_valid_b = 1'b0; abort_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({ctl_a, hit_count_a, hit_map_a} !== {5'b01001, 5'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_a got ctl=%b cnt=%0d map=%h want ctl=01001 cnt=0 map=0000",
               ctl_a, hit_count_a, hit_map_a);
    end
    checks++;
    if ({ctl_b, hit_count_b, hit_map_b} !== {5'b01001, 5'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_b got ctl=%b cnt=%0d map=%h want ctl=01001 cnt=0 map=0000",
               ctl_b, hit_count_b, hit_map_b);
    end
    @(negedge clk);
    checks++;
    if ({ctl_a, ctl_b} !== {5'b00001, 5'b00001}) begin
      errors++;
      $display("FAIL reset_after got a=%b b=%b want 00001", ctl_a, ctl_b);
    end
  endtask

  task automatic test_full_word();
    do_scan(0, 16'b0010100110101011, 5'd0, 1'b0, "full_word");
  endtask

  task automatic test_short_word();
    do_scan(0, 16'h0005, 5'd3, 1'b0, "short_word");
    do_scan(0, 16'hFFFD, 5'd3, 1'b0, "short_upper_ones");
    do_scan(0, 16'h0001, 5'd1, 1'b0, "len_one");
    do_scan(0, 16'h5555, 5'd20, 1'b0, "len_over16");
  endtask

  task automatic test_abort();
    logic [15:0] w;
    logic [4:0]  ecnt;
    logic [15:0] emap;
    w = 16'b0010100110101011;
    data_in_a = w; len_in_a = 5'd0; data_valid_a = 1'b1;
    @(negedge clk);
    data_valid_a = 1'b0;
    for (int n = 1; n < 7; n++) @(negedge clk);
    // SHIFT cycle 5: bits 0..3 have been attributed so far
    model(w, 4, ecnt, emap);
    checks++;
    if ({in_seq_a, hit_count_a, hit_map_a} !== {w[5], ecnt, emap}) begin
      errors++;
      $display("FAIL abort_midscan got in=%b cnt=%0d map=%h want in=%b cnt=%0d map=%h",
               in_seq_a, hit_count_a, hit_map_a, w[5], ecnt, emap);
    end
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    checks++;
    if ({ctl_a, hit_count_a, hit_map_a} !== {5'b01001, 5'd0, 16'd0}) begin
      errors++;
      $display("FAIL abort_next got ctl=%b cnt=%0d map=%h want ctl=01001 cnt=0 map=0000",
               ctl_a, hit_count_a, hit_map_a);
    end
    @(negedge clk);
    checks++;
    if (ctl_a !== 5'b00001) begin
      errors++;
      $display("FAIL abort_after got ctl=%b want 00001", ctl_a);
    end
    do_scan(0, w, 5'd0, 1'b0, "abort_rerun");
  endtask

  task automatic test_abort_idle();
    abort_a = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl_a !== 5'b00001) begin
      errors++;
      $display("FAIL abort_idle got ctl=%b want 00001", ctl_a);
    end
    do_scan(0, 16'h0A5D, 5'd12, 1'b1, "abort_with_hs");
  endtask

  task automatic test_busy_request();
    logic [4:0]  ecnt;
    logic [15:0] emap;
    model(16'h4000, 16, ecnt, emap);
    data_in_a = 16'h4000; len_in_a = 5'd0; data_valid_a = 1'b1;
    @(negedge clk);
    data_in_a = 16'h0035; len_in_a = 5'd8;
    for (int n = 1; n <= 19; n++) begin
      checks++;
      if ({data_ready_a, busy_a, done_a} !== {1'b0, 1'b1, (n == 19)}) begin
        errors++;
        $display("FAIL busy_hold cycle=%0d got rdy=%b busy=%b done=%b want 0 1 %b",
                 n, data_ready_a, busy_a, done_a, (n == 19));
      end
      if (n == 19) begin
        checks++;
        if ({hit_count_a, hit_map_a} !== {ecnt, emap}) begin
          errors++;
          $display("FAIL busy_first got cnt=%0d map=%h want cnt=%0d map=%h",
                   hit_count_a, hit_map_a, ecnt, emap);
        end
      end
      @(negedge clk);
    end
    do_scan(0, 16'h0035, 5'd8, 1'b0, "busy_second");
  endtask

  task automatic test_reset_drain();
    data_in_a = 16'h0005; len_in_a = 5'd3; data_valid_a = 1'b1;
    @(negedge clk);
    data_valid_a = 1'b0;
    for (int n = 1; n < 5; n++) @(negedge clk);
    checks++;
    if (ctl_a !== 5'b00010) begin
      errors++;
      $display("FAIL drain_state got ctl=%b want 00010", ctl_a);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({ctl_a, hit_count_a, hit_map_a} !== {5'b01001, 5'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_drain got ctl=%b cnt=%0d map=%h want ctl=01001 cnt=0 map=0000",
               ctl_a, hit_count_a, hit_map_a);
    end
    @(negedge clk);
    checks++;
    if ({ctl_a, hit_count_a} !== {5'b00001, 5'd0}) begin
      errors++;
      $display("FAIL reset_drain_after got ctl=%b cnt=%0d want ctl=00001 cnt=0",
               ctl_a, hit_count_a);
    end
  endtask

  task automatic test_lat0();
    do_scan(1, 16'hFFFF, 5'd16, 1'b0, "lat0_ffff");
    do_scan(1, 16'b0010100110101011, 5'd0, 1'b0, "lat0_full");
    for (int i = 0; i < 6; i++)
      do_scan(1, 16'($urandom), 5'($urandom_range(0, 31)), 1'b0, "lat0_rand");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      do_scan(0, 16'($urandom), 5'($urandom_range(0, 31)), 1'b0, "rand");
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_short_word();
    test_abort();
    test_abort_idle();
    test_busy_request();
    test_reset_drain();
    test_lat0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

endmodule
